// File: rtl/crypto1_pkg.sv
// Crypto1 LFSR helpers shared by the forward keystream generator and the rollback engine.
// Bit s[47-i] holds LFSR cell x_i; the forward step shifts left and feeds x48 into s[0].
package crypto1_pkg;

  typedef logic [47:0] crypto1_state_t;

  localparam crypto1_state_t CRYPTO1_TAPS = 48'h846B_50D4_1170;

  function automatic logic nlfa(input logic a, input logic b, input logic c, input logic d);
    return ((a | b) ^ (a & d)) ^ (c & ((a ^ b) | d));
  endfunction

  function automatic logic nlfb(input logic a, input logic b, input logic c, input logic d);
    return ((a & b) | c) ^ ((a ^ b) & (c | d));
  endfunction

  function automatic logic nlfc(input logic a, input logic b, input logic c,
                                input logic d, input logic e);
    return (a | ((b | e) & (d ^ e))) ^ ((a ^ (b & d)) & ((c ^ d) | (b & e)));
  endfunction

  // Filter reads the odd cells x9..x47, i.e. the even bits s[38]..s[0].
  function automatic logic crypto1_filter(input crypto1_state_t s);
    return nlfc(nlfa(s[38], s[36], s[34], s[32]),
                nlfb(s[30], s[28], s[26], s[24]),
                nlfb(s[22], s[20], s[18], s[16]),
                nlfa(s[14], s[12], s[10], s[8]),
                nlfb(s[6],  s[4],  s[2],  s[0]));
  endfunction

  // Dropped bit is the one that makes the forward feedback reproduce s[0].
  function automatic crypto1_state_t crypto1_back(input crypto1_state_t s, input logic in);
    crypto1_state_t back_taps;
    logic b;
    back_taps = {CRYPTO1_TAPS[46:0], 1'b0};
    b = s[0] ^ (^(s & back_taps)) ^ in;
    return {b, s[47:1]};
  endfunction

endpackage

// File: rtl/crypto1_rollback_if.sv
// Control/keystream bundle for crypto1_rollback; IN_BIT exists only with CRYPTO1_ROLLBACK_INPUT_EN.
interface crypto1_rollback_if #(parameter int MAX_STEPS = 64);
  import crypto1_pkg::*;

  localparam int SW = $clog2(MAX_STEPS + 1);

  logic           start;
  crypto1_state_t state_in;
  logic [SW-1:0]  steps;
  logic           busy;
  logic           done;
  crypto1_state_t state_out;
  logic           ks_valid;
  logic           ks_ready;
  logic           ks_bit;
`ifdef CRYPTO1_ROLLBACK_INPUT_EN
  logic           in_bit;

  modport master (output start, state_in, steps, ks_ready, in_bit,
                  input  busy, done, state_out, ks_valid, ks_bit);
  modport slave  (input  start, state_in, steps, ks_ready, in_bit,
                  output busy, done, state_out, ks_valid, ks_bit);
`else
  modport master (output start, state_in, steps, ks_ready,
                  input  busy, done, state_out, ks_valid, ks_bit);
  modport slave  (input  start, state_in, steps, ks_ready,
                  output busy, done, state_out, ks_valid, ks_bit);
`endif

endinterface

// File: rtl/crypto1_rollback.sv
// Steps the Crypto1 LFSR backwards one bit per cycle, emitting the filter bit of each recovered state.
// Optional CRYPTO1_ROLLBACK_INPUT_EN adds IN_BIT to undo input mixing of the init phase.
module crypto1_rollback
  import crypto1_pkg::*;
#(
  parameter int MAX_STEPS = 64
) (
  input logic              clk,
  input logic              rst,
  crypto1_rollback_if.slave bus
);

  localparam int SW = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  fsm_t           fsm;
  crypto1_state_t state_q;
  crypto1_state_t prev_state;
  logic [SW-1:0]  cnt;
  logic           busy_q;
  logic           done_q;
  logic           ks_valid_q;
  logic           ks_bit_q;
  logic           in_b;

`ifdef CRYPTO1_ROLLBACK_INPUT_EN
  assign in_b = bus.in_bit;
`else
  assign in_b = 1'b0;
`endif

  assign prev_state = crypto1_back(state_q, in_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= S_IDLE;
      state_q    <= '0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ks_valid_q <= 1'b0;
      ks_bit_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= bus.state_in;
            cnt     <= bus.steps;
            busy_q  <= 1'b1;
            if (bus.steps != '0) begin
              fsm <= S_RUN;
            end else begin
              fsm    <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // The output slot frees up on a handshake, so a new step lands in the same cycle.
          if (!ks_valid_q || bus.ks_ready) begin
            if (ks_valid_q && cnt == '0) begin
              ks_valid_q <= 1'b0;
              fsm        <= S_DONE;
              done_q     <= 1'b1;
            end else begin
              state_q    <= prev_state;
              ks_bit_q   <= crypto1_filter(prev_state);
              ks_valid_q <= 1'b1;
              cnt        <= cnt - 1'b1;
            end
          end
        end
        S_DONE: begin
          fsm    <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          fsm    <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = state_q;
  assign bus.ks_valid  = ks_valid_q;
  assign bus.ks_bit    = ks_bit_q;

endmodule
